// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, runs a req/ready handshake with a multi-cycle instruction
// memory, honours freeze from the hazard unit and branch redirects from ID.
// Optional feature: define IF_FETCH_TIMEOUT_EN to build the imem wait
// counter and the sticky fetch_error flag (tied 0 otherwise).
module if_fetch_unit #(
  parameter int                  WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter int                  MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] PCplus4Out,
  output logic [WORD_LEN-1:0] instructionOut,
  output logic                flushOut,
  output logic                fetch_error
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HELD  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [WORD_LEN-1:0] pc, pc_nxt;
  logic [WORD_LEN-1:0] inst_buf, buf_nxt;
  logic [WORD_LEN-1:0] drain_addr, drain_nxt;
  logic [WORD_LEN-1:0] pc_plus4;

  assign pc_plus4 = pc + {{(WORD_LEN-3){1'b0}}, 3'd4};

  // State, PC, held instruction and the address of an abandoned request
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst_buf   <= '0;
      drain_addr <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst_buf   <= buf_nxt;
      drain_addr <= drain_nxt;
    end
  end

  // Next-state and IF/ID outputs; anything flushed presents an all-zero bubble
  always_comb begin
    state_nxt      = FETCH;
    pc_nxt         = pc;
    buf_nxt        = inst_buf;
    drain_nxt      = drain_addr;
    imem_req       = 1'b0;
    imem_addr      = pc;
    instructionOut = '0;
    PCplus4Out     = '0;
    flushOut       = 1'b1;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req  = 1'b1;
          state_nxt = FETCH;
          if (branch_taken) begin
            pc_nxt = branch_target;
            if (!imem_ready) begin
              // The old request is still in flight and must be drained
              state_nxt = DRAIN;
              drain_nxt = pc;
            end
          end else if (imem_ready) begin
            instructionOut = imem_rdata;
            PCplus4Out     = pc_plus4;
            flushOut       = 1'b0;
            if (freeze) begin
              buf_nxt   = imem_rdata;
              state_nxt = HELD;
            end else begin
              pc_nxt = pc_plus4;
            end
          end
        end
        HELD: begin
          if (branch_taken) begin
            pc_nxt    = branch_target;
            state_nxt = FETCH;
          end else begin
            instructionOut = inst_buf;
            PCplus4Out     = pc_plus4;
            flushOut       = 1'b0;
            if (freeze) begin
              state_nxt = HELD;
            end else begin
              pc_nxt = pc_plus4;
            end
          end
        end
        DRAIN: begin
          // Keep the wrong-path request alive until memory answers, then drop it
          imem_req  = 1'b1;
          imem_addr = drain_addr;
          state_nxt = DRAIN;
          if (branch_taken) begin
            pc_nxt = branch_target;
          end else if (imem_ready) begin
            state_nxt = FETCH;
          end
        end
        default: begin
          if (branch_taken) begin
            pc_nxt = branch_target;
          end
          state_nxt = FETCH;
        end
      endcase
    end
  end

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int                CntW    = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]   WaitLim = CntW'(MAX_WAIT);

  logic [CntW-1:0] wait_cnt;

  // Count unanswered request cycles; the error flag is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
    end else if (imem_req && !imem_ready) begin
      if (wait_cnt != WaitLim) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt >= WaitLim - 1'b1) begin
        fetch_error <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  // No counter is built; the comparison only keeps MAX_WAIT referenced
  assign fetch_error = (MAX_WAIT < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit. The stimulus side
// drives freeze/branch and queues every redirect target; a memory responder
// answers requests with an address-derived word; a monitor tracks the
// architectural instruction stream (sequential PCs, restarting at each
// redirect target) and compares every presented instruction against it.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PCplus4Out;
  logic [31:0] instructionOut;
  logic        flushOut;
  logic        fetch_error;

  int          checks;
  int          passes;
  int          delivered;
  int          mem_mode;
  int          fixed_wait;
  logic [31:0] redir_q[$];

  if_fetch_unit #(
    .WORD_LEN(32),
    .RESET_PC(RESET_PC),
    .MAX_WAIT(15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .PCplus4Out    (PCplus4Out),
    .instructionOut(instructionOut),
    .flushOut      (flushOut),
    .fetch_error   (fetch_error)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents as a pure function of the address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h20080005;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of pipeline-control inputs
  task automatic applyOne(input logic f, input logic b, input logic [31:0] t);
    @(negedge clk);
    freeze       = f;
    branch_taken = b;
    if (b) begin
      branch_target = t;
      redir_q.push_back(t);
    end else begin
      branch_target = $urandom;
    end
  endtask

  // Randomised control inputs; branches never fire on consecutive cycles
  task automatic applyStimulus(input int cycles, input int freeze_pct,
                               input int branch_pct);
    logic        last_b;
    logic        f;
    logic        b;
    logic [31:0] t;
    last_b = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      f = ($urandom_range(0, 99) < freeze_pct);
      b = !last_b && ($urandom_range(0, 99) < branch_pct);
      if ($urandom_range(0, 7) == 0) begin
        t = 32'hFFFF_FFF8;
      end else begin
        t = 32'($urandom_range(0, 1023)) << 2;
      end
      applyOne(f, b, t);
      last_b = b;
    end
  endtask

  // Instruction memory: mode 0 random 0..3 waits, 1 fixed waits, 2 never answers
  initial begin
    int wait_left;
    imem_ready = 1'b0;
    imem_rdata = '0;
    wait_left  = -1;
    forever begin
      @(negedge clk);
      #1;
      if (!imem_req || mem_mode == 2) begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        wait_left  = -1;
      end else begin
        if (wait_left < 0) begin
          wait_left = (mem_mode == 0) ? $urandom_range(0, 3) : fixed_wait;
        end
        if (wait_left == 0) begin
          imem_ready = 1'b1;
          imem_rdata = memWord(imem_addr);
          wait_left  = -1;
        end else begin
          imem_ready = 1'b0;
          imem_rdata = $urandom;
          wait_left--;
        end
      end
    end
  end

  // Monitor: compare presented instructions against the architectural stream
  initial begin
    logic [31:0] exp_addr;
    logic        prev_pending;
    logic        prev_held;
    logic [31:0] prev_addr;
    exp_addr     = RESET_PC;
    prev_pending = 1'b0;
    prev_held    = 1'b0;
    prev_addr    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_flush", {31'd0, flushOut}, 32'd1);
        checkOutput("rst_instruction", instructionOut, 32'd0);
        checkOutput("rst_pcplus4", PCplus4Out, 32'd0);
        exp_addr     = RESET_PC;
        prev_pending = 1'b0;
        prev_held    = 1'b0;
      end else begin
        if (prev_pending && imem_req) begin
          checkOutput("imem_addr_stable", imem_addr, prev_addr);
        end
        if (prev_held) begin
          checkOutput("held_no_request", {31'd0, imem_req}, 32'd0);
        end
        if (branch_taken) begin
          checkOutput("branch_flush", {31'd0, flushOut}, 32'd1);
          checkOutput("redirect_pending", {31'd0, redir_q.size() > 0}, 32'd1);
          if (redir_q.size() > 0) begin
            exp_addr = redir_q.pop_front();
          end
          prev_held = 1'b0;
        end else if (!flushOut) begin
          checkOutput("instruction", instructionOut, memWord(exp_addr));
          checkOutput("pcplus4", PCplus4Out, exp_addr + 32'd4);
          if (freeze) begin
            prev_held = 1'b1;
          end else begin
            exp_addr  = exp_addr + 32'd4;
            delivered++;
            prev_held = 1'b0;
          end
        end else begin
          prev_held = 1'b0;
        end
        prev_pending = imem_req && !imem_ready;
        prev_addr    = imem_addr;
      end
    end
  end

  // Directed phases, random phase, timeout phase, then the summary
  initial begin
    logic exp_err;
    checks        = 0;
    passes        = 0;
    delivered     = 0;
    mem_mode      = 1;
    fixed_wait    = 0;
    rst           = 1'b1;
    freeze        = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] zero-wait sequential fetch");
    applyStimulus(6, 0, 0);

    $display("[TB] three wait states per fetch");
    fixed_wait = 3;
    applyStimulus(12, 0, 0);

    $display("[TB] freeze into HELD, then branch with freeze");
    fixed_wait = 1;
    applyStimulus(4, 0, 0);
    for (int i = 0; i < 6; i++) applyOne(1'b1, 1'b0, 32'h0);
    applyOne(1'b1, 1'b1, 32'h80);
    applyStimulus(6, 0, 0);
    for (int i = 0; i < 4; i++) applyOne(1'b1, 1'b0, 32'h0);
    applyStimulus(4, 0, 0);

    $display("[TB] redirect during a pending request");
    fixed_wait = 3;
    applyStimulus(2, 0, 0);
    applyOne(1'b0, 1'b1, 32'h40);
    applyStimulus(10, 0, 0);

    $display("[TB] randomised traffic");
    mem_mode = 0;
    applyStimulus(3000, 25, 6);

    $display("[TB] withheld memory response");
`ifdef IF_FETCH_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    mem_mode     = 2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) begin
        @(negedge clk);
        #2;
      end
      if (i == 15) checkOutput("fetch_error_before_limit", {31'd0, fetch_error}, 32'd0);
      if (i == 16) checkOutput("fetch_error_at_limit", {31'd0, fetch_error}, {31'd0, exp_err});
      if (i == 20) checkOutput("fetch_error_sticky", {31'd0, fetch_error}, {31'd0, exp_err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("fetch_error_reset", {31'd0, fetch_error}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    mem_mode = 0;
    applyStimulus(40, 10, 5);
    @(negedge clk);
    #3;
    checkOutput("fetch_error_short_waits", {31'd0, fetch_error}, 32'd0);
    checkOutput("delivery_count_ok", {31'd0, delivered >= 300}, 32'd1);
    checkOutput("redirects_consumed", 32'(redir_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
